// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b type definitions.
//   lc3b_word       16-bit data/address word
//   lc3b_mem_wmask  2-bit byte-lane mask
//   lc3b_arb_state  memory arbiter FSM states
//   arb_req_t       one captured requester command {read, write, address, wdata, byte_enable}
//   arb_make_req    packs requester inputs into arb_req_t, resolving read+write to a read
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_BUSY_P0 = 2'b01,
    ARB_BUSY_P1 = 2'b10
  } lc3b_arb_state;

  localparam logic          ARB_PORT0            = 1'b0;
  localparam logic          ARB_PORT1            = 1'b1;
  localparam lc3b_mem_wmask ARB_IDLE_BYTE_ENABLE = 2'b11;

  typedef struct packed {
    logic          read;
    logic          write;
    lc3b_word      address;
    lc3b_word      wdata;
    lc3b_mem_wmask byte_enable;
  } arb_req_t;

  // A requester that raises read and write together gets a read; the write
  // is dropped here so the downstream command is never ambiguous.
  function automatic arb_req_t arb_make_req(
    input logic          read,
    input logic          write,
    input lc3b_word      address,
    input lc3b_word      wdata,
    input lc3b_mem_wmask byte_enable
  );
    arb_req_t r;
    r.read        = read;
    r.write       = write & ~read;
    r.address     = address;
    r.wdata       = wdata;
    r.byte_enable = byte_enable;
    return r;
  endfunction

endpackage

// File: rtl/arb_req_reg.sv
// arb_req_reg: load-enabled holding register for the granted command.
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high clear
//   load   in   capture d on the next rising edge
//   d      in   command to capture
//   q      out  captured command
module arb_req_reg
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     load,
  input  arb_req_t d,
  output arb_req_t q
);

  // Holds the command steady for the whole transaction, independent of
  // whatever the requester does with its inputs afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single physical memory.
//   clk, reset                         clock and synchronous active-high reset
//   p0_* (instruction side)            read/write/address/wdata/byte_enable in,
//                                      rdata/resp out
//   p1_* (data side)                   same as port 0
//   pmem_read/write/address/wdata/
//   pmem_byte_enable                   downstream command, from latched registers only
//   pmem_rdata, pmem_resp              downstream read data and completion pulse
module mem_arbiter
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,

  input  logic          p0_read,
  input  logic          p0_write,
  input  lc3b_word      p0_address,
  input  lc3b_word      p0_wdata,
  input  lc3b_mem_wmask p0_byte_enable,
  output lc3b_word      p0_rdata,
  output logic          p0_resp,

  input  logic          p1_read,
  input  logic          p1_write,
  input  lc3b_word      p1_address,
  input  lc3b_word      p1_wdata,
  input  lc3b_mem_wmask p1_byte_enable,
  output lc3b_word      p1_rdata,
  output logic          p1_resp,

  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  output lc3b_mem_wmask pmem_byte_enable,
  input  lc3b_word      pmem_rdata,
  input  logic          pmem_resp
);

  lc3b_arb_state state;
  lc3b_arb_state next_state;
  logic          last_grant;
  logic          next_last_grant;

  logic          p0_req;
  logic          p1_req;
  arb_req_t      p0_cmd;
  arb_req_t      p1_cmd;
  logic          load;
  arb_req_t      load_cmd;
  arb_req_t      held_cmd;

  assign p0_req = p0_read | p0_write;
  assign p1_req = p1_read | p1_write;

  assign p0_cmd = arb_make_req(p0_read, p0_write, p0_address, p0_wdata, p0_byte_enable);
  assign p1_cmd = arb_make_req(p1_read, p1_write, p1_address, p1_wdata, p1_byte_enable);

  // Read data goes straight through; each port qualifies it with its own resp.
  assign p0_rdata = pmem_rdata;
  assign p1_rdata = pmem_rdata;

  arb_req_reg u_req_reg (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .d     (load_cmd),
    .q     (held_cmd)
  );

  // State and round-robin history. After reset last_grant points at port 1
  // so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_grant <= ARB_PORT1;
    end else begin
      state      <= next_state;
      last_grant <= next_last_grant;
    end
  end

  // Grant decision, command capture and downstream drive. Every transaction
  // returns to IDLE on pmem_resp, which guarantees one idle cycle between
  // transactions and gives the other port a fair look at the next tie.
  always_comb begin
    next_state       = state;
    next_last_grant  = last_grant;
    load             = 1'b0;
    load_cmd         = p0_cmd;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    pmem_byte_enable = ARB_IDLE_BYTE_ENABLE;
    p0_resp          = 1'b0;
    p1_resp          = 1'b0;

    case (state)
      ARB_IDLE: begin
        if (p0_req && (!p1_req || (last_grant == ARB_PORT1))) begin
          next_state      = ARB_BUSY_P0;
          next_last_grant = ARB_PORT0;
          load            = 1'b1;
          load_cmd        = p0_cmd;
        end else if (p1_req) begin
          next_state      = ARB_BUSY_P1;
          next_last_grant = ARB_PORT1;
          load            = 1'b1;
          load_cmd        = p1_cmd;
        end
      end

      ARB_BUSY_P0, ARB_BUSY_P1: begin
        pmem_read        = held_cmd.read;
        pmem_write       = held_cmd.write;
        pmem_address     = held_cmd.address;
        pmem_wdata       = held_cmd.wdata;
        pmem_byte_enable = held_cmd.byte_enable;
        if (pmem_resp) begin
          next_state = ARB_IDLE;
          if (state == ARB_BUSY_P0) begin
            p0_resp = 1'b1;
          end else begin
            p1_resp = 1'b1;
          end
        end
      end

      default: begin
        next_state = ARB_IDLE;
      end
    endcase

    // While reset is held the outputs look idle, so an aborted transaction
    // never shows a command or a completion pulse.
    if (reset) begin
      pmem_read        = 1'b0;
      pmem_write       = 1'b0;
      pmem_address     = '0;
      pmem_wdata       = '0;
      pmem_byte_enable = ARB_IDLE_BYTE_ENABLE;
      p0_resp          = 1'b0;
      p1_resp          = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. Requests are pushed to
// a scoreboard as they are driven and popped when the downstream command
// appears; a small memory responder completes each transaction.
module tb_mem_arbiter;
  import lc3b_types::*;

  logic          clk;
  logic          reset;
  logic          p0_read, p0_write, p1_read, p1_write;
  lc3b_word      p0_address, p0_wdata, p1_address, p1_wdata;
  lc3b_mem_wmask p0_byte_enable, p1_byte_enable;
  lc3b_word      p0_rdata, p1_rdata;
  logic          p0_resp, p1_resp;
  logic          pmem_read, pmem_write;
  lc3b_word      pmem_address, pmem_wdata, pmem_rdata;
  lc3b_mem_wmask pmem_byte_enable;
  logic          pmem_resp;

  int checks = 0;
  int errors = 0;

  // mode: 0 plain, 1 requester changes address/wdata mid-transaction,
  // 2 requester drops its request mid-transaction
  typedef struct {
    bit            port;
    bit            read;
    bit            write;
    lc3b_word      addr;
    lc3b_word      wdata;
    lc3b_mem_wmask be;
    int            delay;
    lc3b_word      rdata;
    int            mode;
    bit            hold;
  } vec_t;

  vec_t sb[$];

  mem_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .p0_read          (p0_read),
    .p0_write         (p0_write),
    .p0_address       (p0_address),
    .p0_wdata         (p0_wdata),
    .p0_byte_enable   (p0_byte_enable),
    .p0_rdata         (p0_rdata),
    .p0_resp          (p0_resp),
    .p1_read          (p1_read),
    .p1_write         (p1_write),
    .p1_address       (p1_address),
    .p1_wdata         (p1_wdata),
    .p1_byte_enable   (p1_byte_enable),
    .p1_rdata         (p1_rdata),
    .p1_resp          (p1_resp),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_byte_enable (pmem_byte_enable),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges beyond the per-wait bounds.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(bit port, bit rd, bit wr, lc3b_word addr, lc3b_word wdata,
                                 lc3b_mem_wmask be, int delay, lc3b_word rdata, int mode, bit hold);
    vec_t v;
    v.port = port; v.read = rd; v.write = wr; v.addr = addr; v.wdata = wdata;
    v.be = be; v.delay = delay; v.rdata = rdata; v.mode = mode; v.hold = hold;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic setCmd(input bit port, input bit rd, input bit wr);
    if (port) begin p1_read = rd; p1_write = wr; end
    else      begin p0_read = rd; p0_write = wr; end
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.port) begin
      p1_address = v.addr; p1_wdata = v.wdata; p1_byte_enable = v.be;
    end else begin
      p0_address = v.addr; p0_wdata = v.wdata; p0_byte_enable = v.be;
    end
    setCmd(v.port, v.read, v.write);
    sb.push_back(v);
  endtask

  // Waits for the downstream command, pops the scoreboard and compares.
  task automatic waitCmd(output vec_t e, output bit ok);
    int waited = 0;
    ok = 1'b0;
    e = mkVec(0, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0, 0, 0);
    @(negedge clk); #1;
    while (!(pmem_read || pmem_write) && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!(pmem_read || pmem_write)) begin
      checkOutput("cmd_timeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("grant_latency", waited, 0);
    if (sb.size() == 0) begin
      checkOutput("sb_underflow", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    ok = 1'b1;
    checkOutput("pmem_read", pmem_read, e.read);
    checkOutput("pmem_write", pmem_write, e.write && !e.read);
    checkOutput("pmem_address", pmem_address, e.addr);
    checkOutput("pmem_wdata", pmem_wdata, e.wdata);
    checkOutput("pmem_byte_enable", pmem_byte_enable, e.be);
  endtask

  // Memory responder: holds off for e.delay cycles, pulses pmem_resp, then
  // checks the completion pulse and the idle gap that follows.
  task automatic finishTxn(input vec_t e);
    for (int i = 0; i < e.delay; i++) begin
      if (i == 0 && e.mode == 1) begin
        if (e.port) begin p1_address = e.addr + 16'h0100; p1_wdata = ~e.wdata; end
        else        begin p0_address = e.addr + 16'h0100; p0_wdata = ~e.wdata; end
      end
      if (i == 0 && e.mode == 2) setCmd(e.port, 1'b0, 1'b0);
      @(negedge clk); #1;
      checkOutput("addr_hold", pmem_address, e.addr);
      checkOutput("wdata_hold", pmem_wdata, e.wdata);
      checkOutput("cmd_hold", pmem_read | pmem_write, 1);
      checkOutput("early_resp", {p0_resp, p1_resp}, 2'b00);
    end
    pmem_rdata = e.rdata;
    pmem_resp  = 1'b1;
    #1;
    checkOutput("resp", {p0_resp, p1_resp}, e.port ? 2'b01 : 2'b10);
    checkOutput("rdata", e.port ? p1_rdata : p0_rdata, e.rdata);
    checkOutput("cmd_at_resp", pmem_read | pmem_write, 1);
    @(negedge clk);
    pmem_resp = 1'b0;
    if (!e.hold) setCmd(e.port, 1'b0, 1'b0);
    #1;
    checkOutput("idle_gap_cmd", {pmem_read, pmem_write}, 2'b00);
    checkOutput("idle_gap_resp", {p0_resp, p1_resp}, 2'b00);
    checkOutput("idle_gap_addr", pmem_address, 16'h0000);
  endtask

  task automatic serveOne();
    vec_t e;
    bit ok;
    waitCmd(e, ok);
    if (ok) finishTxn(e);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_cmd"}, {pmem_read, pmem_write}, 2'b00);
    checkOutput({tag, "_be"}, pmem_byte_enable, 2'b11);
    checkOutput({tag, "_addr"}, pmem_address, 16'h0000);
    checkOutput({tag, "_wdata"}, pmem_wdata, 16'h0000);
    checkOutput({tag, "_resp"}, {p0_resp, p1_resp}, 2'b00);
  endtask

  initial begin
    vec_t tbl[6];
    vec_t e;
    bit   ok;

    tbl[0] = mkVec(0, 1, 0, 16'h0040, 16'h0000, 2'b11, 3, 16'h1234, 0, 0);
    tbl[1] = mkVec(1, 0, 1, 16'h0100, 16'hBEEF, 2'b01, 1, 16'h0000, 0, 0);
    tbl[2] = mkVec(0, 1, 1, 16'h0080, 16'h5555, 2'b10, 0, 16'hA5A5, 0, 0);
    tbl[3] = mkVec(1, 1, 0, 16'h0200, 16'h0F0F, 2'b11, 4, 16'h0F0F, 1, 0);
    tbl[4] = mkVec(0, 0, 1, 16'h1000, 16'hCAFE, 2'b11, 2, 16'h0000, 2, 0);
    tbl[5] = mkVec(1, 1, 1, 16'hFFFE, 16'h3C3C, 2'b01, 1, 16'hFFFF, 2, 0);

    reset = 1'b1;
    pmem_resp = 1'b0; pmem_rdata = 16'h0;
    p0_read = 1'b1; p0_write = 1'b0; p0_address = 16'h0040; p0_wdata = 16'h0; p0_byte_enable = 2'b11;
    p1_read = 1'b0; p1_write = 1'b1; p1_address = 16'h0100; p1_wdata = 16'h0; p1_byte_enable = 2'b11;

    $display("[TB] reset with requests asserted");
    @(negedge clk); @(negedge clk); #1;
    checkIdleOutputs("reset_held");
    setCmd(0, 0, 0); setCmd(1, 0, 0);
    reset = 1'b0;
    @(negedge clk); #1;
    checkIdleOutputs("after_reset");

    $display("[TB] tie after reset: port 0 first, then port 1 write");
    applyStimulus(mkVec(0, 1, 0, 16'h0040, 16'h0000, 2'b11, 2, 16'h2222, 0, 0));
    applyStimulus(mkVec(1, 0, 1, 16'h0100, 16'hBEEF, 2'b01, 1, 16'h0000, 0, 0));
    serveOne();
    serveOne();

    $display("[TB] single-port vector table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i]);
      serveOne();
    end

    $display("[TB] stray pmem_resp while idle");
    pmem_rdata = 16'h7777;
    pmem_resp  = 1'b1;
    #1;
    checkIdleOutputs("stray_resp");
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    checkIdleOutputs("stray_resp_after");

    $display("[TB] both ports held for six transactions");
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) applyStimulus(mkVec(0, 1, 0, 16'h2000, 16'h0000, 2'b11, i % 3, 16'h1000 + 16'(i), 0, 1));
      else            applyStimulus(mkVec(1, 0, 1, 16'h3000, 16'h4321, 2'b10, i % 3, 16'h0000, 0, 1));
    end
    for (int i = 0; i < 6; i++) serveOne();
    setCmd(0, 0, 0); setCmd(1, 0, 0);
    checkOutput("sb_drained", sb.size(), 0);

    $display("[TB] reset during a port 1 write");
    applyStimulus(mkVec(1, 0, 1, 16'h0200, 16'h1111, 2'b11, 0, 16'h0000, 0, 0));
    waitCmd(e, ok);
    @(negedge clk);
    reset = 1'b1;
    pmem_resp = 1'b1;
    #1;
    checkOutput("abort_resp_in_reset", {p0_resp, p1_resp}, 2'b00);
    checkOutput("abort_write_in_reset", pmem_write, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    pmem_resp = 1'b0;
    #1;
    checkIdleOutputs("after_abort");
    applyStimulus(mkVec(0, 1, 0, 16'h0044, 16'h0000, 2'b11, 1, 16'h9999, 0, 0));
    applyStimulus(mkVec(1, 0, 1, 16'h0200, 16'h1111, 2'b11, 1, 16'h0000, 0, 0));
    serveOne();
    serveOne();
    checkOutput("sb_final", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
